// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation pump controller family.
//   ST_*        : controller FSM state codes
//   clog2_min1  : index width helper, never returns less than 1
//   cnt_w       : width of the shared tick / gap cycle counter
package irrigation_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WATER = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One counter serves both the seconds prescaler and the pump-off gap,
  // so it must hold max(TICK_DIV, GAP_CYCLES)-1.
  function automatic int cnt_w(input int tick_div, input int gap_cycles);
    return clog2_min1((tick_div > gap_cycles) ? tick_div : gap_cycles);
  endfunction

endpackage

// File: rtl/multi_zone_pump_ctrl_if.sv
// Per-zone request handshake bundle.
//   req_valid : zone i presents a watering request
//   req_time  : zone i duration in seconds at [i*TIME_W +: TIME_W]
//   req_ready : controller can accept a request from zone i
// master = the fuzzy stages issuing requests, slave = the controller.
interface multi_zone_pump_ctrl_if #(
  parameter int NUM_ZONES = 4,
  parameter int TIME_W    = 8
);
  logic [NUM_ZONES-1:0]        req_valid;
  logic [NUM_ZONES*TIME_W-1:0] req_time;
  logic [NUM_ZONES-1:0]        req_ready;

  modport master (output req_valid, req_time, input  req_ready);
  modport slave  (input  req_valid, req_time, output req_ready);
endinterface

// File: rtl/zone_rr_arbiter.sv
// Combinational round-robin pick.
//   pending   : request bit per zone
//   last_zone : zone granted most recently
//   gnt_valid : at least one zone pending
//   gnt_idx   : first pending zone at or after last_zone+1, wrapping
module zone_rr_arbiter
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int ZONE_W    = clog2_min1(NUM_ZONES)
) (
  input  logic [NUM_ZONES-1:0] pending,
  input  logic [ZONE_W-1:0]    last_zone,
  output logic                 gnt_valid,
  output logic [ZONE_W-1:0]    gnt_idx
);

  int j;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 1; k <= NUM_ZONES; k++) begin
      j = (int'(last_zone) + k) % NUM_ZONES;
      if (!gnt_valid && pending[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ZONE_W'(j);
      end
    end
  end

endmodule

// File: rtl/multi_zone_pump_ctrl.sv
// Multi-zone irrigation pump controller: latches one request per zone,
// waters one zone at a time in round-robin order, counts seconds with an
// internal prescaler, enforces a pump-off gap between zones, and cancels on
// rain or stop.
//   clk, reset           : clock, synchronous active-high reset
//   req                  : per-zone request handshake (slave side)
//   rain_present, stop   : inhibit / global cancel
//   pump_on              : one-hot relay drive
//   active_zone          : zone being watered, 0 otherwise
//   watering_in_progress : any pump on
//   watering_timer       : seconds left for the active zone, 0 otherwise
//   sensor_enable        : high only while idle
//   done_pulse           : zone finished its full duration
//   abort_pulse          : zone cut short by rain/stop
module multi_zone_pump_ctrl
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES  = 4,
  parameter int TIME_W     = 8,
  parameter int TICK_DIV   = 50_000_000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  multi_zone_pump_ctrl_if.slave               req,
  input  logic                                rain_present,
  input  logic                                stop,
  output logic [NUM_ZONES-1:0]                pump_on,
  output logic [clog2_min1(NUM_ZONES)-1:0]    active_zone,
  output logic                                watering_in_progress,
  output logic [TIME_W-1:0]                   watering_timer,
  output logic                                sensor_enable,
  output logic [NUM_ZONES-1:0]                done_pulse,
  output logic [NUM_ZONES-1:0]                abort_pulse
);

  localparam int ZONE_W = clog2_min1(NUM_ZONES);
  localparam int CNT_W  = cnt_w(TICK_DIV, GAP_CYCLES);

  logic [1:0]                        state;
  logic [NUM_ZONES-1:0]              pending;
  logic [NUM_ZONES-1:0][TIME_W-1:0]  dur;
  logic [ZONE_W-1:0]                 cur_zone, last_zone;
  logic [TIME_W-1:0]                 timer;
  logic [CNT_W-1:0]                  cnt;
  logic [NUM_ZONES-1:0]              ready;
  logic                              gnt_valid;
  logic [ZONE_W-1:0]                 gnt_idx;

  zone_rr_arbiter #(.NUM_ZONES(NUM_ZONES), .ZONE_W(ZONE_W)) u_arb (
    .pending   (pending),
    .last_zone (last_zone),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++)
      ready[i] = !pending[i] && !(state == ST_WATER && cur_zone == ZONE_W'(i));
  end
  assign req.req_ready = ready;

  always_comb begin
    pump_on = '0;
    if (state == ST_WATER) pump_on[cur_zone] = 1'b1;
  end

  assign watering_in_progress = (state == ST_WATER);
  assign sensor_enable        = (state == ST_IDLE);
  assign active_zone          = (state == ST_WATER) ? cur_zone : '0;
  assign watering_timer       = (state == ST_WATER) ? timer : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      dur         <= '0;
      cur_zone    <= '0;
      last_zone   <= ZONE_W'(NUM_ZONES - 1);
      timer       <= '0;
      cnt         <= '0;
      done_pulse  <= '0;
      abort_pulse <= '0;
    end else begin
      done_pulse  <= '0;
      abort_pulse <= '0;

      // zero-length requests complete the handshake but leave nothing behind
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (req.req_valid[i] && ready[i] && req.req_time[i*TIME_W +: TIME_W] != '0) begin
          pending[i] <= 1'b1;
          dur[i]     <= req.req_time[i*TIME_W +: TIME_W];
        end
      end

      case (state)
        ST_IDLE: begin
          if (!rain_present && !stop && gnt_valid) begin
            state            <= ST_WATER;
            pending[gnt_idx] <= 1'b0;
            timer            <= dur[gnt_idx];
            cnt              <= '0;
            cur_zone         <= gnt_idx;
            last_zone        <= gnt_idx;
          end
        end
        ST_WATER: begin
          if (stop || rain_present) begin
            state                 <= ST_GAP;
            abort_pulse[cur_zone] <= 1'b1;
            timer                 <= '0;
            cnt                   <= '0;
          end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt <= '0;
            if (timer == TIME_W'(1)) begin
              state                <= ST_GAP;
              done_pulse[cur_zone] <= 1'b1;
              timer                <= '0;
            end else begin
              timer <= timer - TIME_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // stop overrides any accept or grant bookkeeping this cycle
      if (stop) pending <= '0;
    end
  end

endmodule
